// File: rtl/hdmi_video_out.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_video_out
// Description : Video timing generator and AXI4-Stream to HDMI pixel output
//               stage with start-of-frame lock and error recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_video_out #(
    parameter int          H_ACTIVE   = 1920,
    parameter int          H_FP       = 88,
    parameter int          H_SYNC     = 44,
    parameter int          H_BP       = 148,
    parameter int          V_ACTIVE   = 1080,
    parameter int          V_FP       = 4,
    parameter int          V_SYNC     = 5,
    parameter int          V_BP       = 36,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter logic [15:0] BLANK_DATA = 16'h8010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [15:0] hdmi_data,
    output logic        hdmi_data_e,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic        locked,
    output logic        underflow,
    output logic        frame_err,
    input  logic        status_clr,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] c_h_last = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_v_last = VW'(V_TOTAL - 1);

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic            w_active;
    logic            w_sof_pos;
    logic            w_line_end;
    logic            w_hs_on;
    logic            w_vs_on;
    logic            w_frame_bad;
    logic            w_ready;
    logic            w_pix_ok;
    logic            w_uf_evt;
    logic            w_fe_evt;

    assign w_active   = (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
    assign w_sof_pos  = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_line_end = (int'(r_hcnt) == H_ACTIVE - 1);
    assign w_hs_on    = (int'(r_hcnt) >= H_ACTIVE + H_FP) &&
                        (int'(r_hcnt) <  H_ACTIVE + H_FP + H_SYNC);
    // vcnt only moves on an hcnt wrap, so vsync edges land at hcnt=0.
    assign w_vs_on    = (int'(r_vcnt) >= V_ACTIVE + V_FP) &&
                        (int'(r_vcnt) <  V_ACTIVE + V_FP + V_SYNC);

    assign w_frame_bad = (s_axis_tuser && !w_sof_pos) || (s_axis_tlast != w_line_end);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_pix_ok    = 1'b0;
        w_uf_evt    = 1'b0;
        w_fe_evt    = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                w_ready = !s_axis_tuser || w_sof_pos;
                if (s_axis_tvalid && s_axis_tuser && w_sof_pos) begin
                    w_pix_ok    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = w_active && !w_frame_bad;
                if (w_active) begin
                    if (!s_axis_tvalid) begin
                        w_uf_evt    = 1'b1;
                        w_state_nxt = ST_WAIT_SOF;
                    end else if (w_frame_bad) begin
                        w_fe_evt    = 1'b1;
                        w_state_nxt = ST_WAIT_SOF;
                    end else begin
                        w_pix_ok = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_SOF;
        endcase
        // A held SOF beat must not slip through while reset is applied.
        if (reset) begin
            w_ready = 1'b0;
        end
    end

    assign s_axis_tready = w_ready;
    assign locked        = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_SOF;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            hdmi_data   <= BLANK_DATA;
            hdmi_data_e <= 1'b0;
            hdmi_hsync  <= !HS_POL;
            hdmi_vsync  <= !VS_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_hcnt == c_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == c_v_last) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            hdmi_data   <= w_pix_ok ? s_axis_tdata : BLANK_DATA;
            hdmi_data_e <= w_active;
            hdmi_hsync  <= w_hs_on ? HS_POL : !HS_POL;
            hdmi_vsync  <= w_vs_on ? VS_POL : !VS_POL;
            frame_start <= w_sof_pos;
            underflow   <= (underflow && !status_clr) || w_uf_evt;
            frame_err   <= (frame_err && !status_clr) || w_fe_evt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_video_out
// Description : Randomized scoreboard bench for hdmi_video_out (small raster).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_out;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [15:0] BLANK = 16'h8010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [15:0] hdmi_data;
    logic        hdmi_data_e, hdmi_hsync, hdmi_vsync;
    logic        locked, underflow, frame_err, frame_start;
    logic        status_clr = 1'b0;

    always #5 clk = ~clk;

    hdmi_video_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .BLANK_DATA(BLANK)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .hdmi_data(hdmi_data), .hdmi_data_e(hdmi_data_e),
        .hdmi_hsync(hdmi_hsync), .hdmi_vsync(hdmi_vsync),
        .locked(locked), .underflow(underflow), .frame_err(frame_err),
        .status_clr(status_clr), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        de, hs, vs, fs, lk, uf, fe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: raster position as a single frame-cycle index.
    int p = 0;
    bit m_lock = 0, m_uf = 0, m_fe = 0;

    // Upstream source: a frame buffer walked beat by beat.
    int          sx = 0, sy = 0;
    logic [15:0] sdata;
    bit          f_user = 0, f_last = 0;
    bit          armed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] new_beat(input int x, input int y);
        return {8'($urandom), 4'(y), 4'(x)};
    endfunction

    task automatic src_restart();
        sx = 0; sy = 0; f_user = 0; f_last = 0;
        sdata = new_beat(0, 0);
    endtask

    task automatic src_advance();
        f_user = 0; f_last = 0;
        sx++;
        if (sx == HA) begin
            sx = 0;
            sy = (sy + 1) % VA;
        end
        sdata = new_beat(sx, sy);
    endtask

    task automatic cycle(input bit rst_in, input bit valid_in, input bit clr_in);
        int   h, v;
        bit   act, sofp, tu, tl, rdy, bad, uev, fev;
        exp_t e;
        @(negedge clk);
        reset         = rst_in;
        s_axis_tvalid = valid_in;
        s_axis_tdata  = sdata;
        tu            = ((sx == 0) && (sy == 0)) ^ f_user;
        tl            = (sx == HA - 1) ^ f_last;
        s_axis_tuser  = tu;
        s_axis_tlast  = tl;
        status_clr    = clr_in;
        #1;
        h = p % HT; v = p / HT;
        act  = (h < HA) && (v < VA);
        sofp = (p == 0);
        if (rst_in) begin
            e = '{data: BLANK, de: 0, hs: 0, vs: 0, fs: 0, lk: 0, uf: 0, fe: 0};
            p = 0; m_lock = 0; m_uf = 0; m_fe = 0;
            src_restart();
        end else begin
            rdy = 0; uev = 0; fev = 0;
            e.data = BLANK;
            if (!m_lock) begin
                rdy = !tu || sofp;
                if (valid_in && tu && sofp) begin
                    e.data = sdata;
                    m_lock = 1;
                end
            end else if (act) begin
                bad = (tu && !sofp) || (tl != (h == HA - 1));
                rdy = !bad;
                if (!valid_in) begin
                    uev = 1; m_lock = 0;
                end else if (bad) begin
                    fev = 1; m_lock = 0;
                end else begin
                    e.data = sdata;
                end
            end
            chk("tready", 32'(s_axis_tready), 32'(rdy));
            m_uf = (m_uf && !clr_in) || uev;
            m_fe = (m_fe && !clr_in) || fev;
            e.de = act;
            e.hs = (h >= HA + HF) && (h < HA + HF + HS);
            e.vs = (v >= VA + VF) && (v < VA + VF + VS);
            e.fs = sofp;
            e.lk = m_lock;
            e.uf = m_uf;
            e.fe = m_fe;
            p = (p + 1) % FT;
            if (valid_in && rdy) src_advance();
        end
        q.push_back(e);
    endtask

    // mode: 0 idle, 1 stream, 2 stream + one drop at (3,2),
    //       3 stream + one bad tlast at source pixel (5,1), 4 random faults
    task automatic run(input int n, input int mode);
        bit vld, clr;
        for (int i = 0; i < n; i++) begin
            vld = (mode != 0);
            clr = 0;
            if (mode == 2 && armed && m_lock && p == 2 * HT + 3) begin
                vld = 0; armed = 0;
            end
            if (mode == 3 && armed && m_lock && sx == 5 && sy == 1) begin
                f_last = 1; armed = 0;
            end
            if (mode == 4) begin
                vld = ($urandom_range(0, 39) != 0);
                clr = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 199) == 0) f_user = 1;
                if ($urandom_range(0, 199) == 0) f_last = 1;
                if ($urandom_range(0, 299) == 0) src_restart();
            end
            cycle(1'b0, vld, clr);
        end
    endtask

    exp_t mon_e;
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("hdmi_data",   32'(hdmi_data),   32'(mon_e.data));
            chk("hdmi_data_e", 32'(hdmi_data_e), 32'(mon_e.de));
            chk("hdmi_hsync",  32'(hdmi_hsync),  32'(mon_e.hs));
            chk("hdmi_vsync",  32'(hdmi_vsync),  32'(mon_e.vs));
            chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
            chk("locked",      32'(locked),      32'(mon_e.lk));
            chk("underflow",   32'(underflow),   32'(mon_e.uf));
            chk("frame_err",   32'(frame_err),   32'(mon_e.fe));
        end
    end

    initial begin
        src_restart();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        run(2 * FT + 20, 0);              // free run, then SOF offered mid-frame
        run(3 * FT, 1);                   // lock and stream continuous frames
        armed = 1;
        run(2 * FT, 2);                   // underflow at (3,2), resync next frame
        cycle(1'b0, 1'b1, 1'b1);          // clear sticky flags
        run(FT, 1);
        armed = 1;
        run(2 * FT, 3);                   // tlast framing error on line 1
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < FT && p != 2 * HT + 4; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);          // one-cycle reset mid-frame at (4,2)
        run(2 * FT, 1);
        run(8 * FT, 4);                   // randomized faults and clears
        run(2 * FT, 1);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
